// File: rtl/trap_sequencer_pkg.sv
// rtl/trap_sequencer_pkg.sv - shared encodings for the trap entry / MRET return sequencer
package trap_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_RET  = 1'b1
  } kind_t;

  // mstatus bit positions, shared with the CSR file
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

endpackage

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - sequences trap entry and MRET return: flush, drain, redirect, CSR ack
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int DRAIN_MAX = 15,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             initiate_exception,
  input  logic             mret,
  input  logic [31:0]      csr_mtvec,
  input  logic [31:0]      csr_mepc,
  input  logic             mem_busy,
  input  logic             redir_ready,
  output logic             flush,
  output logic             stall,
  output logic             redir_valid,
  output logic [31:0]      redir_pc,
  output logic             trap_ack,
  output logic             mret_ack,
  output logic             drain_timeout,
  output logic [CNT_W-1:0] trap_count
);

  localparam int DW = $clog2(DRAIN_MAX + 1);

  state_t          state, state_nxt;
  kind_t           kind;
  logic [31:0]     target;
  logic [DW-1:0]   drain_cnt;
  logic            accept_trap, accept_ret, drain_expire, drain_done, handshake;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{csr_mtvec[1:0], csr_mepc[1:0]};

  // A trap beats a simultaneous MRET; requests outside RUN are dropped
  assign accept_trap  = (state == ST_RUN) && initiate_exception;
  assign accept_ret   = (state == ST_RUN) && mret && !initiate_exception;
  assign drain_expire = (state == ST_DRAIN) && (drain_cnt == DW'(DRAIN_MAX - 1));
  assign drain_done   = (state == ST_DRAIN) && (!mem_busy || drain_expire);
  assign handshake    = (state == ST_REDIRECT) && redir_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:      if (accept_trap || accept_ret) state_nxt = ST_DRAIN;
      ST_DRAIN:    if (drain_done) state_nxt = ST_REDIRECT;
      ST_REDIRECT: if (handshake) state_nxt = ST_RUN;
      default:     state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    flush       = 1'b0;
    stall       = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    trap_ack    = accept_trap;
    mret_ack    = 1'b0;
    case (state)
      ST_DRAIN: begin
        flush = 1'b1;
        stall = 1'b1;
      end
      ST_REDIRECT: begin
        stall       = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = target;
        mret_ack    = redir_ready && (kind == KIND_RET);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kind          <= KIND_TRAP;
      target        <= '0;
      drain_cnt     <= '0;
      drain_timeout <= 1'b0;
      trap_count    <= '0;
    end else begin
      if (accept_trap) begin
        kind   <= KIND_TRAP;
        target <= {csr_mtvec[31:2], 2'b00};
        if (trap_count != '1) trap_count <= trap_count + 1'b1;
      end else if (accept_ret) begin
        kind   <= KIND_RET;
        target <= {csr_mepc[31:2], 2'b00};
      end
      if (state == ST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else if (handshake)    drain_cnt <= '0;
      // Timeout only counts when memory is still busy at the limit
      if (drain_expire && mem_busy) drain_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - directed self-checking bench for trap_sequencer
module tb_trap_sequencer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             initiate_exception, mret, mem_busy, redir_ready;
  logic [31:0]      csr_mtvec, csr_mepc;
  logic             flush, stall, redir_valid, trap_ack, mret_ack, drain_timeout;
  logic [31:0]      redir_pc;
  logic [CNT_W-1:0] trap_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  trap_sequencer #(.DRAIN_MAX(15), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .initiate_exception (initiate_exception),
    .mret               (mret),
    .csr_mtvec          (csr_mtvec),
    .csr_mepc           (csr_mepc),
    .mem_busy           (mem_busy),
    .redir_ready        (redir_ready),
    .flush              (flush),
    .stall              (stall),
    .redir_valid        (redir_valid),
    .redir_pc           (redir_pc),
    .trap_ack           (trap_ack),
    .mret_ack           (mret_ack),
    .drain_timeout      (drain_timeout),
    .trap_count         (trap_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then changed 1ns after the edge, outputs read 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plain trap with idle memory and ready fetch: RUN, DRAIN, REDIRECT, back to RUN
  task automatic quick_trap(input logic [31:0] vec);
    csr_mtvec = vec; initiate_exception = 1'b1; mem_busy = 1'b0; redir_ready = 1'b1;
    tick();
    initiate_exception = 1'b0;
    tick();
    tick();
    if (exp_count < 15) exp_count++;
  endtask

  initial begin
    reset = 1'b1; initiate_exception = 1'b0; mret = 1'b0; mem_busy = 1'b0;
    redir_ready = 1'b0; csr_mtvec = '0; csr_mepc = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_redir_valid", 32'(redir_valid), 32'd0);
    check("rst_count", 32'(trap_count), 32'd0);
    check("rst_timeout", 32'(drain_timeout), 32'd0);

    // 1: reset while sitting in REDIRECT
    csr_mtvec = 32'h0000_0040; initiate_exception = 1'b1;
    tick();
    initiate_exception = 1'b0;
    tick();
    #1;
    check("t1_redirect_reached", 32'(redir_valid), 32'd1);
    check("t1_count_before", 32'(trap_count), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t1_redir_valid", 32'(redir_valid), 32'd0);
    check("t1_flush", 32'(flush), 32'd0);
    check("t1_stall", 32'(stall), 32'd0);
    check("t1_count", 32'(trap_count), 32'd0);
    check("t1_timeout", 32'(drain_timeout), 32'd0);

    // 2: trap with idle memory
    csr_mtvec = 32'h0000_0107; initiate_exception = 1'b1; mem_busy = 1'b0; redir_ready = 1'b1;
    #1;
    check("t2_c0_trap_ack", 32'(trap_ack), 32'd1);
    check("t2_c0_flush", 32'(flush), 32'd0);
    tick();
    initiate_exception = 1'b0; csr_mtvec = 32'hFFFF_FFFF;
    #1;
    check("t2_c1_flush", 32'(flush), 32'd1);
    check("t2_c1_stall", 32'(stall), 32'd1);
    check("t2_c1_redir_pc", redir_pc, 32'd0);
    check("t2_c1_trap_ack", 32'(trap_ack), 32'd0);
    tick();
    #1;
    check("t2_c2_redir_valid", 32'(redir_valid), 32'd1);
    check("t2_c2_redir_pc", redir_pc, 32'h0000_0104);
    check("t2_c2_flush", 32'(flush), 32'd0);
    check("t2_c2_mret_ack", 32'(mret_ack), 32'd0);
    tick();
    #1;
    check("t2_c3_run", 32'({flush, stall, redir_valid}), 32'd0);
    check("t2_count", 32'(trap_count), 32'd1);

    // 3: MRET with 4 busy drain cycles and 2 cycles of redirect back-pressure
    csr_mepc = 32'h8000_0010; mret = 1'b1; mem_busy = 1'b1; redir_ready = 1'b0;
    #1;
    check("t3_c0_trap_ack", 32'(trap_ack), 32'd0);
    check("t3_c0_mret_ack", 32'(mret_ack), 32'd0);
    tick();
    mret = 1'b0; csr_mepc = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      mem_busy = (i < 4);
      #1;
      check($sformatf("t3_drain%0d_flush", i), 32'(flush), 32'd1);
      check($sformatf("t3_drain%0d_acks", i), 32'({trap_ack, mret_ack}), 32'd0);
      tick();
    end
    mem_busy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      redir_ready = (j == 2);
      #1;
      check($sformatf("t3_redir%0d_valid", j), 32'(redir_valid), 32'd1);
      check($sformatf("t3_redir%0d_pc", j), redir_pc, 32'h8000_0010);
      check($sformatf("t3_redir%0d_mret_ack", j), 32'(mret_ack), 32'(j == 2));
      check($sformatf("t3_redir%0d_trap_ack", j), 32'(trap_ack), 32'd0);
      tick();
    end
    #1;
    check("t3_back_run", 32'({flush, stall, redir_valid, mret_ack}), 32'd0);
    check("t3_count", 32'(trap_count), 32'd1);

    // 4: trap and MRET together; trap wins
    csr_mtvec = 32'h2000_0203; csr_mepc = 32'h0000_1234;
    initiate_exception = 1'b1; mret = 1'b1; mem_busy = 1'b0; redir_ready = 1'b1;
    #1;
    check("t4_trap_ack", 32'(trap_ack), 32'd1);
    check("t4_c0_mret_ack", 32'(mret_ack), 32'd0);
    tick();
    initiate_exception = 1'b0; mret = 1'b0;
    #1;
    check("t4_c1_mret_ack", 32'(mret_ack), 32'd0);
    tick();
    #1;
    check("t4_redir_pc", redir_pc, 32'h2000_0200);
    check("t4_c2_mret_ack", 32'(mret_ack), 32'd0);
    tick();
    check("t4_count", 32'(trap_count), 32'd2);

    // 5: memory stuck busy forces redirect after 15 drain cycles
    csr_mtvec = 32'h0000_0300; initiate_exception = 1'b1; mem_busy = 1'b1; redir_ready = 1'b1;
    tick();
    initiate_exception = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      check($sformatf("t5_drain%0d_flush", i), 32'(flush), 32'd1);
      check($sformatf("t5_drain%0d_timeout", i), 32'(drain_timeout), 32'd0);
      tick();
    end
    #1;
    check("t5_redirect", 32'({flush, redir_valid}), 32'b01);
    check("t5_timeout_set", 32'(drain_timeout), 32'd1);
    tick();
    mem_busy = 1'b0;
    exp_count = 3;
    quick_trap(32'h0000_0500);
    check("t5_timeout_sticky", 32'(drain_timeout), 32'd1);
    check("t5_count", 32'(trap_count), 32'(exp_count));

    // 6a: request held high through DRAIN/REDIRECT is ignored, then retaken in RUN
    csr_mtvec = 32'h0000_0600; initiate_exception = 1'b1; mem_busy = 1'b0; redir_ready = 1'b1;
    #1;
    check("t6_c0_trap_ack", 32'(trap_ack), 32'd1);
    tick();
    #1;
    check("t6_drain_trap_ack", 32'(trap_ack), 32'd0);
    tick();
    #1;
    check("t6_redir_trap_ack", 32'(trap_ack), 32'd0);
    tick();
    #1;
    check("t6_rerun_trap_ack", 32'(trap_ack), 32'd1);
    tick();
    initiate_exception = 1'b0;
    tick(); tick();
    exp_count += 2;
    check("t6_count", 32'(trap_count), 32'(exp_count));

    // 6b: saturation at all-ones after reset; timeout cleared by reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t6_timeout_cleared", 32'(drain_timeout), 32'd0);
    exp_count = 0;
    for (int n = 0; n < 20; n++) begin
      quick_trap(32'h0000_1000 + 32'(n));
      check($sformatf("t6_sat_count%0d", n), 32'(trap_count), 32'(exp_count));
    end
    check("t6_sat_final", 32'(trap_count), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
